// File: rtl/alu_arbiter.sv
// alu_arbiter: two requesters sharing one combinational ALU, alternating priority
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0_valid,
  input  logic req1_valid,
  output logic req0_ready,
  output logic req1_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [OP_W-1:0] req0_op,
  input  logic [OP_W-1:0] req1_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0] alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic alu_zero,
  output logic rsp0_valid,
  output logic rsp1_valid,
  input  logic rsp0_ready,
  input  logic rsp1_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic [DATA_W-1:0] rsp1_result,
  output logic rsp0_zero,
  output logic rsp1_zero,
  output logic busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, next;
  logic prio, gnt, sel, accept, rsp_hs, zero0, zero1;
  logic [DATA_W-1:0] a_q, b_q, res0, res1;
  logic [OP_W-1:0] op_q;
  // grant selection, handshakes and next state; ready is held low during reset
  always_comb begin
    sel = (req0_valid & req1_valid) ? prio : req1_valid;
    req0_ready = rst_n & (state == IDLE) & req0_valid & ~sel;
    req1_ready = rst_n & (state == IDLE) & req1_valid & sel;
    accept = req0_ready | req1_ready;
    rsp_hs = (state == RESP) & (gnt ? rsp1_ready : rsp0_ready);
    next = (state == IDLE) ? (accept ? EXEC : IDLE) :
           (state == EXEC) ? RESP :
           (state == RESP) ? (rsp_hs ? IDLE : RESP) : IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= next;
  // operand capture on accept, per-requester result capture in EXEC, priority flip on response
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prio <= 1'b0;
      gnt <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
      res0 <= '0;
      res1 <= '0;
      zero0 <= 1'b0;
      zero1 <= 1'b0;
    end else begin
      if (accept) begin
        gnt <= sel;
        a_q <= sel ? req1_a : req0_a;
        b_q <= sel ? req1_b : req0_b;
        op_q <= sel ? req1_op : req0_op;
      end
      if (state == EXEC && !gnt) begin
        res0 <= alu_result;
        zero0 <= alu_zero;
      end
      if (state == EXEC && gnt) begin
        res1 <= alu_result;
        zero1 <= alu_zero;
      end
      if (rsp_hs) prio <= ~gnt;
    end
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_op = op_q;
  assign rsp0_valid = (state == RESP) & ~gnt;
  assign rsp1_valid = (state == RESP) & gnt;
  assign rsp0_result = res0;
  assign rsp1_result = res1;
  assign rsp0_zero = zero0;
  assign rsp1_zero = zero1;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, latency, backpressure and reset
`timescale 1ns/1ps
module tb_alu_arbiter;
  logic clk = 0, rst_n = 0;
  logic req0_valid = 0, req1_valid = 0, req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [3:0] req0_op = 0, req1_op = 0, alu_op;
  logic [31:0] alu_a, alu_b, alu_result, rsp0_result, rsp1_result;
  logic alu_zero, rsp0_valid, rsp1_valid, rsp0_ready = 0, rsp1_ready = 0;
  logic rsp0_zero, rsp1_zero, busy;
  int n_chk = 0, n_fail = 0;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp0_result(rsp0_result), .rsp1_result(rsp1_result),
    .rsp0_zero(rsp0_zero), .rsp1_zero(rsp1_zero),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // stand-in shared ALU
  always_comb begin
    case (alu_op)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h3: alu_result = alu_a | alu_b;
      4'h7: alu_result = 32'h0;
      4'hF: alu_result = 32'hDEADBEEF;
      default: alu_result = alu_a ^ alu_b;
    endcase
    alu_zero = alu_result == 32'h0;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " ready"}, {req0_ready, req1_ready}, 0);
    check({tag, " rsp_valid"}, {rsp0_valid, rsp1_valid}, 0);
    check({tag, " alu"}, {alu_a, alu_b[27:0], alu_op}, 0);
    check({tag, " rsp0"}, {rsp0_result, rsp0_zero}, 0);
    check({tag, " rsp1"}, {rsp1_result, rsp1_zero}, 0);
  endtask

  // single-requester transaction with fixed 3-cycle timing
  task automatic txn(input bit n, input logic [31:0] a, b, input logic [3:0] op,
                     input logic [31:0] er, input logic ez, input string tag);
    if (n) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1; end
    else begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1; end
    #1;
    check({tag, " ready"}, {req0_ready, req1_ready}, n ? 2'b01 : 2'b10);
    step();
    req0_valid = 0;
    req1_valid = 0;
    #1;
    check({tag, " exec"}, {busy, rsp0_valid, rsp1_valid, alu_op}, {3'b100, op});
    step();
    check({tag, " rsp_valid"}, {rsp0_valid, rsp1_valid}, n ? 2'b01 : 2'b10);
    check({tag, " result"}, n ? {rsp1_result, rsp1_zero} : {rsp0_result, rsp0_zero}, {er, ez});
    if (n) rsp1_ready = 1; else rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    rsp1_ready = 0;
    #1;
    check({tag, " idle"}, {busy, rsp0_valid, rsp1_valid}, 0);
  endtask

  initial begin
    #2;
    check_reset("por");
    step();
    rst_n = 1;
    txn(0, 5, 3, 4'h0, 8, 0, "add");
    // mid-cycle async reset while a request is being accepted
    req0_a = 9; req0_b = 1; req0_op = 4'h1; req0_valid = 1;
    step();
    #2 rst_n = 0;
    #1 check_reset("async");
    req0_valid = 0;
    step();
    rst_n = 1;
    // both valid after reset: requester 0 wins
    req0_a = 7; req0_b = 7; req0_op = 4'h1; req0_valid = 1;
    req1_a = 32'hF0; req1_b = 32'h0F; req1_op = 4'h3; req1_valid = 1;
    #1 check("both first", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    #1 check("both exec", {req1_ready, busy}, 2'b01);
    step();
    check("both rsp0", {rsp0_valid, rsp1_valid, rsp0_result, rsp0_zero}, {2'b10, 32'h0, 1'b1});
    rsp0_ready = 1;
    step();
    rsp0_ready = 0;
    #1 check("both second", {req0_ready, req1_ready}, 2'b01);
    step();
    req1_valid = 0;
    step();
    check("both rsp1", {rsp0_valid, rsp1_valid, rsp1_result, rsp1_zero}, {2'b01, 32'hFF, 1'b0});
    check("rsp0 held", {rsp0_result, rsp0_zero}, {32'h0, 1'b1});
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    // both again: priority back at requester 0; serve op F under backpressure
    req0_a = 1; req0_b = 2; req0_op = 4'hF; req0_valid = 1;
    req1_a = 3; req1_b = 9; req1_op = 4'h7; req1_valid = 1;
    #1 check("again first", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    step();
    rsp1_ready = 1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp hold", {rsp0_valid, rsp1_valid, req1_ready, busy, rsp0_result, rsp0_zero},
            {4'b1001, 32'hDEADBEEF, 1'b0});
      step();
    end
    rsp1_ready = 0;
    rsp0_ready = 1;
    #1 check("bp no early accept", req1_ready, 0);
    step();
    rsp0_ready = 0;
    #1 check("bp then accept", {req0_ready, req1_ready, busy}, 3'b010);
    step();
    req1_valid = 0;
    step();
    check("op7 rsp1", {rsp1_valid, rsp1_result, rsp1_zero}, {1'b1, 32'h0, 1'b1});
    rsp1_ready = 1;
    step();
    rsp1_ready = 0;
    // serve req0 so priority sits at requester 1, then reset during req1 EXEC
    txn(0, 32'hFFFFFFFF, 1, 4'h0, 0, 1, "wrap");
    req1_a = 4; req1_b = 4; req1_op = 4'h0; req1_valid = 1;
    #1 check("r1 ready", req1_ready, 1);
    step();
    req1_valid = 0;
    #2 rst_n = 0;
    #1 check_reset("exec rst");
    step();
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      check("no stale rsp", {rsp1_valid, busy}, 0);
      step();
    end
    req0_valid = 1; req1_valid = 1;
    #1 check("prio reset", {req0_ready, req1_ready}, 2'b10);
    req1_valid = 0;
    req0_valid = 0;
    #1;
    txn(0, 10, 4, 4'h5, 32'hE, 0, "after rst");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width.
REQ-002 Parameter: OP_W, 4, ALU opcode width.
REQ-003 Clocking SHALL be one clock; reset is asynchronous and active-low.
REQ-004 Port: clk  input  1  sole clock, rising edge.
REQ-005 Port: rst_n  input  1  asynchronous active-low reset.
REQ-006 Ports: req0_valid / req1_valid  input  1  requester N has an operation pending.
REQ-007 Ports: req0_ready / req1_ready  output  1  operation from requester N accepted this cycle.
REQ-008 Ports: req0_a, req0_b / req1_a, req1_b  input  DATA_W  operands.
REQ-009 Ports: req0_op / req1_op  input  OP_W  ALU opcode.
REQ-010 Ports: alu_a, alu_b  output  DATA_W; alu_op  output  OP_W  drive the shared combinational ALU.
REQ-011 Ports: alu_result  input  DATA_W; alu_zero  input  1  ALU outputs.
REQ-012 Ports: rsp0_valid / rsp1_valid  output  1  result for requester N available.
REQ-013 Ports: rsp0_ready / rsp1_ready  input  1  requester N consumes result.
REQ-014 Ports: rsp0_result / rsp1_result  output  DATA_W; rsp0_zero / rsp1_zero  output  1  captured result/flag.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 FSM SHALL have states IDLE, EXEC, RESP; one transaction in flight at a time.
REQ-017 IDLE: if no reqN_valid, stay IDLE, all reqN_ready low.
REQ-018 IDLE, one valid: that requester is granted; both valid: requester holding priority is granted.
REQ-019 reqN_ready SHALL be combinational, high only in IDLE, only for the granted requester, only while its valid is high; at most one ready high per cycle.
REQ-020 On valid&ready: a, b, op, grant index registered; next state EXEC.
REQ-021 alu_a/alu_b/alu_op SHALL always equal the operand registers (no combinational path from req inputs).
REQ-022 EXEC (one cycle): alu_result/alu_zero captured into result registers; next state RESP.
REQ-023 RESP: rspN_valid high for granted N only; result/zero stable until rspN_ready handshake.
REQ-024 On rspN_valid&rspN_ready: priority moves to the other requester; next state IDLE.
REQ-025 Latency: accept at edge T -> rspN_valid high from T+2; minimum 3 cycles per transaction.
REQ-026 Opcodes SHALL pass unmodified, including 4'b1111 and undefined codes; no opcode checking.
REQ-027 Changes on req inputs during EXEC/RESP SHALL not affect in-flight operands or result.
REQ-028 rspN_result/rspN_zero of the non-granted requester SHALL hold last captured values; only rsp*_valid qualifies them.
REQ-029 rspN_ready while rspN_valid low SHALL be ignored.

Reset
REQ-030 On rst_n low, immediately: state IDLE, priority to requester 0, operand/result registers 0, all valid/ready/busy low.
REQ-031 Reset mid-EXEC or mid-RESP SHALL discard the transaction; no response issued after release.
REQ-032 First accept possible on first rising edge after rst_n deasserts.

Verification
REQ-033 Reset: rst_n low asynchronously mid-cycle -> all outputs 0 before next edge, busy 0.
REQ-034 req0 only, a=5 b=3 op=0000 -> req0_ready at T, rsp0_valid at T+2, rsp0_result=8, rsp0_zero=0, rsp1_valid stays 0.
REQ-035 After reset, both valid: req0 a=7 b=7 op=0001, req1 a=0xF0 b=0x0F op=0011 -> req0 served first (result 0, zero 1), then req1 (result 0xFF, zero 0); then both again -> req0 served first (priority back to req0 after req1 served).
REQ-036 Backpressure: rsp0_ready low 5 cycles with req1_valid high -> rsp0_valid, result held; req1_ready stays 0; busy 1; accept of req1 only after handshake.
REQ-037 op=1111, any operands -> rspN_result=0xDEADBEEF, zero 0; op=0111 -> result 0, zero 1.
REQ-038 rst_n pulsed low during EXEC of req1 -> no rsp1_valid after release; next req0 accepted normally with priority at req0.
